// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder block: FSM state
// encoding, digit-counter sizing and the full-adder cell equations.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle between an operand source (master) and
// the digit-serial adder (slave).
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, carry, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, carry, ovf
    );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells; also
// exposes the carry entering the top bit for signed-overflow detection.
module digit_adder
    import adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] chain_s;

    assign chain_s[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]           = fa_sum(x[i], y[i], chain_s[i]);
        assign chain_s[i + 1] = fa_carry(x[i], y[i], chain_s[i]);
    end

    assign co    = chain_s[DIGIT];
    assign c_top = chain_s[DIGIT - 1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: DIGIT bits per clock with a registered carry,
// start/busy/done handshake, and registered sum, carry-out and signed overflow.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $fatal(1, "digit_serial_adder: DIGIT must divide WIDTH exactly");
    end

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] psum_r;
    logic             carry_r;

    logic [DIGIT-1:0] sum_dig_s;
    logic             co_s;
    logic             c_top_s;
    logic [WIDTH-1:0] psum_next_s;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x     (a_sr_r[DIGIT-1:0]),
        .y     (b_sr_r[DIGIT-1:0]),
        .ci    (carry_r),
        .s     (sum_dig_s),
        .co    (co_s),
        .c_top (c_top_s)
    );

    // New digit enters at the MSB end; after NDIG shifts the LSB digit lands at bit 0.
    assign psum_next_s = (psum_r >> DIGIT) | (WIDTH'(sum_dig_s) << (WIDTH - DIGIT));

    // Control FSM, operand/partial-sum shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            a_sr_r    <= {WIDTH{1'b0}};
            b_sr_r    <= {WIDTH{1'b0}};
            psum_r    <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.sum   <= {WIDTH{1'b0}};
            bus.carry <= 1'b0;
            bus.ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr_r   <= bus.a;
                        b_sr_r   <= bus.b;
                        carry_r  <= bus.cin;
                        cnt_r    <= {CW{1'b0}};
                        psum_r   <= {WIDTH{1'b0}};
                        bus.busy <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        bus.busy <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_r  <= a_sr_r >> DIGIT;
                    b_sr_r  <= b_sr_r >> DIGIT;
                    psum_r  <= psum_next_s;
                    carry_r <= co_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r     <= {CW{1'b0}};
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.sum   <= psum_next_s;
                        bus.carry <= co_s;
                        bus.ovf   <= c_top_s ^ co_s;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed, table-driven bench for digit_serial_adder in three configurations:
// 8-bit/2-bit digits, 2-bit/1-bit digits (exhaustive) and 8-bit single digit.
module tb_digit_serial_adder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    digit_serial_adder_if #(.WIDTH(8)) bus8 ();
    digit_serial_adder_if #(.WIDTH(2)) bus2 ();
    digit_serial_adder_if #(.WIDTH(8)) busf ();

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    digit_serial_adder #(.WIDTH(2), .DIGIT(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dutf (.clk(clk), .rst(rst), .bus(busf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return bus8.done;
            1:       return bus2.done;
            default: return busf.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return bus8.busy;
            1:       return bus2.busy;
            default: return busf.busy;
        endcase
    endfunction

    // Entered at the falling edge after the accepting edge (cycle 1).
    task automatic wait_done(input int sel, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (get_done(sel) !== 1'b1 && lat < 20) begin
            if (get_busy(sel) === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, output int lat, output int bcnt);
        @(negedge clk);
        case (sel)
            0:       begin bus8.a = a;      bus8.b = b;      bus8.cin = cin; bus8.start = 1'b1; end
            1:       begin bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.cin = cin; bus2.start = 1'b1; end
            default: begin busf.a = a;      busf.b = b;      busf.cin = cin; busf.start = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance to prove they were captured.
        bus8.start = 1'b0; bus8.a = ~bus8.a; bus8.b = ~bus8.b; bus8.cin = ~bus8.cin;
        bus2.start = 1'b0; bus2.a = ~bus2.a; bus2.b = ~bus2.b; bus2.cin = ~bus2.cin;
        busf.start = 1'b0; busf.a = ~busf.a; busf.b = ~busf.b; busf.cin = ~busf.cin;
        wait_done(sel, lat, bcnt);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dones;
        logic [2:0] tot;
        logic [1:0] a2, b2, s2;
        logic       c2, o2;

        errors = 0;
        checks = 0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = 2'b00; bus2.b = 2'b00; bus2.cin = 1'b0;
        busf.start = 1'b0; busf.a = 8'h00; busf.b = 8'h00; busf.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {19'd0, bus8.busy, bus8.done, bus8.carry, bus8.ovf, bus8.sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {30'd0, bus8.busy, bus8.done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            op(0, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
            chk($sformatf("vec%0d_sum", i), {24'd0, bus8.sum}, {24'd0, vecs[i].s});
            chk($sformatf("vec%0d_carry", i), {31'd0, bus8.carry}, {31'd0, vecs[i].c});
            chk($sformatf("vec%0d_ovf", i), {31'd0, bus8.ovf}, {31'd0, vecs[i].o});
            chk($sformatf("vec%0d_latency", i), lat, 32'd5);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd4);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, bus8.done}, 32'd0);
            chk($sformatf("vec%0d_sum_held", i), {24'd0, bus8.sum}, {24'd0, vecs[i].s});
        end

        // start held high across RUN/DONE while operand a changes.
        @(negedge clk);
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.a = 8'h11;
        wait_done(0, lat, bcnt);
        chk("hold_latency", lat, 32'd5);
        chk("hold_sum", {24'd0, bus8.sum}, 32'h02);
        @(negedge clk);
        chk("hold_after_done", {30'd0, bus8.busy, bus8.done}, 32'd0);
        chk("hold_sum_kept", {24'd0, bus8.sum}, 32'h02);
        @(negedge clk);
        chk("hold_reaccept_busy", {31'd0, bus8.busy}, 32'd1);
        chk("hold_sum_during_run", {24'd0, bus8.sum}, 32'h02);
        bus8.start = 1'b0;
        wait_done(0, lat, bcnt);
        chk("hold_second_sum", {24'd0, bus8.sum}, 32'h12);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", {19'd0, bus8.busy, bus8.done, bus8.carry, bus8.ovf, bus8.sum}, 32'd0);
        #2 rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
        end
        chk("no_done_after_reset", dones, 32'd0);
        chk("idle_after_reset", {31'd0, bus8.busy}, 32'd0);
        op(0, 8'h03, 8'h04, 1'b0, lat, bcnt);
        chk("post_reset_sum", {24'd0, bus8.sum}, 32'h07);
        chk("post_reset_latency", lat, 32'd5);

        // Exhaustive 2-bit, one bit per cycle.
        for (int v = 0; v < 32; v++) begin
            a2  = 2'(v >> 3);
            b2  = 2'(v >> 1);
            tot = {1'b0, a2} + {1'b0, b2} + {2'b00, 1'(v)};
            s2  = tot[1:0];
            c2  = tot[2];
            o2  = (a2[1] == b2[1]) && (s2[1] != a2[1]);
            op(1, {6'd0, a2}, {6'd0, b2}, 1'(v), lat, bcnt);
            chk($sformatf("w2_%0d_result", v), {29'd0, bus2.carry, bus2.ovf, bus2.sum},
                {29'd0, c2, o2, s2});
            chk($sformatf("w2_%0d_latency", v), lat, 32'd3);
        end

        // Single-digit configuration.
        op(2, 8'h7F, 8'h01, 1'b0, lat, bcnt);
        chk("full_sum", {24'd0, busf.sum}, 32'h80);
        chk("full_carry_ovf", {30'd0, busf.carry, busf.ovf}, 32'd1);
        chk("full_latency", lat, 32'd2);
        chk("full_busy_cycles", bcnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
